conv_result_sink: RTL and testbench

//  Consumer end of the Sobel convolution output stream (valid-only, no backpressure, 18-bit magnitude).

---
 rtl/conv_pkg.sv | 18 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/conv_result_sink.sv | 131 +++++++++++++
 tb/tb_conv_result_sink.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types for the convolution result sink: FIFO entry layout and receive-FSM states.
package conv_pkg;

   localparam int OUT_WIDTH_DEF = 12;

   typedef struct packed {
      logic                     sof;
      logic                     eol;
      logic                     eof;
      logic [OUT_WIDTH_DEF-1:0] pix;
   } sink_entry_t;

   typedef enum logic {
      S_IDLE,
      S_FRAME
   } sink_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read and a registered occupancy count.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             push_ok;
   logic             pop_ok;

   assign o_full  = (count == CW'(DEPTH));
   assign o_empty = (count == '0);
   assign pop_ok  = i_pop && !o_empty;
   assign push_ok = i_push && (!o_full || i_pop);
   assign o_data  = mem[rd_ptr];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: nothing is read out while the FIFO is empty.
   always_ff @(posedge i_clk) begin
      if (push_ok) mem[wr_ptr] <= i_data;
   end

endmodule

// File: rtl/conv_result_sink.sv
// Sobel output sink: raster tagging, border zeroing, saturation, buffering to a ready/valid pixel port.
// Optional binary threshold stage enabled by defining CONV_SINK_THRESH_EN.
//
// state   | meaning
// S_IDLE  | between frames, waiting for the (0,0) sample
// S_FRAME | frame in progress, until the last sample of the frame arrives
module conv_result_sink
   import conv_pkg::*;
#(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int IN_WIDTH   = 18,
   parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_val_valid,
   input  logic [IN_WIDTH-1:0]  i_val,
`ifdef CONV_SINK_THRESH_EN
   input  logic [OUT_WIDTH-1:0] i_threshold,
`endif
   output logic                 o_pix_valid,
   input  logic                 i_pix_ready,
   output logic [OUT_WIDTH-1:0] o_pix,
   output logic                 o_pix_sof,
   output logic                 o_pix_eol,
   output logic                 o_frame_done,
   output logic                 o_busy,
   output logic                 o_overflow
);

   localparam int XW = $clog2(IMG_WIDTH);
   localparam int YW = $clog2(IMG_HEIGHT);
   localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);
   localparam logic [XW-1:0] X_TWO  = XW'(2);
   localparam logic [YW-1:0] Y_TWO  = YW'(2);

   logic [XW-1:0]    x;
   logic [YW-1:0]    y;
   logic [OUT_WIDTH-1:0] sat_val;
   logic [OUT_WIDTH-1:0] pix_val;
   logic             border;
   sink_entry_t      in_entry;
   sink_entry_t      head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;
   sink_state_t      state;
   sink_state_t      state_nxt;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         x <= '0;
         y <= '0;
      end else if (i_val_valid) begin
         if (x == X_LAST) begin
            x <= '0;
            y <= (y == Y_LAST) ? '0 : y + 1'b1;
         end else begin
            x <= x + 1'b1;
         end
      end
   end

   always_comb begin
      sat_val = (|i_val[IN_WIDTH-1:OUT_WIDTH]) ? '1 : i_val[OUT_WIDTH-1:0];
`ifdef CONV_SINK_THRESH_EN
      pix_val = (sat_val >= i_threshold) ? '1 : '0;
`else
      pix_val = sat_val;
`endif
      border       = (x < X_TWO) || (y < Y_TWO);
      in_entry     = '0;
      in_entry.sof = (x == '0) && (y == '0);
      in_entry.eol = (x == X_LAST);
      in_entry.eof = (x == X_LAST) && (y == Y_LAST);
      in_entry.pix = border ? '0 : OUT_WIDTH_DEF'(pix_val);
   end

   sync_fifo #(
      .WIDTH ($bits(sink_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (i_val_valid),
      .i_data  (in_entry),
      .i_pop   (pop),
      .o_data  (head),
      .o_full  (fifo_full),
      .o_empty (fifo_empty)
   );

   assign pop         = !fifo_empty && i_pix_ready;
   assign o_pix_valid = !fifo_empty;
   // Gate the head with valid so stale storage never shows on the port.
   assign o_pix       = fifo_empty ? '0 : OUT_WIDTH'(head.pix);
   assign o_pix_sof   = !fifo_empty && head.sof;
   assign o_pix_eol   = !fifo_empty && head.eol;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_overflow   <= 1'b0;
         o_frame_done <= 1'b0;
      end else begin
         if (i_val_valid && fifo_full && !pop) o_overflow <= 1'b1;
         o_frame_done <= pop && head.eof;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (i_val_valid && in_entry.sof) state_nxt = S_FRAME;
         S_FRAME: if (i_val_valid && in_entry.eof) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_busy = (state == S_FRAME);
   end

endmodule

// File: tb/tb_conv_result_sink.sv
// Scoreboard bench for conv_result_sink on a 4x4 raster with a 4-entry buffer.
module tb_conv_result_sink;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int IW = 18;
   localparam int OW = 12;
   localparam int D  = 4;

   logic          i_clk = 1'b0;
   logic          i_rst = 1'b1;
   logic          i_val_valid = 1'b0;
   logic [IW-1:0] i_val = '0;
   logic          i_pix_ready = 1'b0;
`ifdef CONV_SINK_THRESH_EN
   logic [OW-1:0] i_threshold = 12'd50;
`endif
   logic          o_pix_valid;
   logic [OW-1:0] o_pix;
   logic          o_pix_sof;
   logic          o_pix_eol;
   logic          o_frame_done;
   logic          o_busy;
   logic          o_overflow;

   conv_result_sink #(
      .IMG_WIDTH  (W),
      .IMG_HEIGHT (H),
      .IN_WIDTH   (IW),
      .OUT_WIDTH  (OW),
      .FIFO_DEPTH (D)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_val_valid  (i_val_valid),
      .i_val        (i_val),
`ifdef CONV_SINK_THRESH_EN
      .i_threshold  (i_threshold),
`endif
      .o_pix_valid  (o_pix_valid),
      .i_pix_ready  (i_pix_ready),
      .o_pix        (o_pix),
      .o_pix_sof    (o_pix_sof),
      .o_pix_eol    (o_pix_eol),
      .o_frame_done (o_frame_done),
      .o_busy       (o_busy),
      .o_overflow   (o_overflow)
   );

   always #5 i_clk = ~i_clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Expected entries: {sof, eol, eof, pix}
   logic [OW+2:0] exp_q[$];
   int mdl_cnt = 0;
   int smp_n   = 0;
   bit exp_ovf = 1'b0;
   bit exp_busy = 1'b0;
   bit fd_exp = 1'b0;
   int fd_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [OW+2:0] ref_entry(input int n, input logic [IW-1:0] v);
      int x;
      int y;
      int mag;
      logic [OW-1:0] p;
      x   = n % W;
      y   = n / W;
      mag = int'(v);
      p   = (mag > 4095) ? 12'hFFF : OW'(mag);
`ifdef CONV_SINK_THRESH_EN
      p = (p >= i_threshold) ? 12'hFFF : 12'h000;
`endif
      if (x < 2 || y < 2) p = '0;
      return {(x == 0 && y == 0), (x == W - 1), (x == W - 1 && y == H - 1), p};
   endfunction

   // Reference model: occupancy, drops, frame state, evaluated at each sampling edge.
   always @(posedge i_clk) begin : model
      bit pop_m;
      bit acc;
      logic [OW+2:0] e;
      if (!i_rst) begin
         pop_m = i_pix_ready && (mdl_cnt > 0);
         acc   = 1'b0;
         if (i_val_valid) begin
            e   = ref_entry(smp_n, i_val);
            acc = (mdl_cnt < D) || pop_m;
            if (acc) exp_q.push_back(e);
            else     exp_ovf = 1'b1;
            if (e[OW+2])    exp_busy = 1'b1;
            else if (e[OW]) exp_busy = 1'b0;
            smp_n = (smp_n + 1) % (W * H);
         end
         mdl_cnt = mdl_cnt + int'(acc) - int'(pop_m);
      end
   end

   always @(negedge i_clk) begin : monitor
      logic [OW+2:0] e;
      bit fd_next;
      if (!i_rst) begin
         chk("pix_valid", 32'(o_pix_valid), 32'(mdl_cnt != 0));
         chk("overflow", 32'(o_overflow), 32'(exp_ovf));
         chk("busy", 32'(o_busy), 32'(exp_busy));
         chk("frame_done", 32'(o_frame_done), 32'(fd_exp));
         if (o_frame_done) fd_seen++;
         fd_next = 1'b0;
         if (o_pix_valid && i_pix_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL entry_unexpected: got pix %0h with nothing expected", o_pix);
            end else begin
               e = exp_q.pop_front();
               chk("entry{sof,eol,pix}", {17'd0, o_pix_sof, o_pix_eol, 1'b0, o_pix},
                   {17'd0, e[OW+2], e[OW+1], 1'b0, e[OW-1:0]});
               fd_next = e[OW];
            end
         end
         fd_exp = fd_next;
      end
   end

   task automatic step(input bit v, input logic [IW-1:0] d, input bit r);
      @(posedge i_clk);
      #1;
      i_val_valid = v;
      i_val       = d;
      i_pix_ready = r;
   endtask

   task automatic do_reset();
      @(posedge i_clk);
      #3;
      i_rst = 1'b1;
      #1;
      chk("rst_pix_valid", 32'(o_pix_valid), 32'd0);
      chk("rst_pix", 32'(o_pix), 32'd0);
      chk("rst_sof_eol", {30'd0, o_pix_sof, o_pix_eol}, 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_overflow", 32'(o_overflow), 32'd0);
      chk("rst_frame_done", 32'(o_frame_done), 32'd0);
      i_val_valid = 1'b0;
      i_pix_ready = 1'b0;
      exp_q.delete();
      mdl_cnt  = 0;
      smp_n    = 0;
      exp_ovf  = 1'b0;
      exp_busy = 1'b0;
      fd_exp   = 1'b0;
      fd_seen  = 0;
      repeat (2) @(posedge i_clk);
      #3;
      i_rst = 1'b0;
   endtask

   task automatic drain();
      int budget;
      budget = 60;
      step(1'b0, '0, 1'b1);
      while (mdl_cnt != 0 && budget > 0) begin
         step(1'b0, '0, 1'b1);
         budget--;
      end
      if (budget == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain_timeout: %0d entries still expected", mdl_cnt);
      end
      step(1'b0, '0, 1'b1);
   endtask

   function automatic logic [IW-1:0] rand_val();
      case ($urandom_range(0, 5))
         0:       return 18'h3FFFF;
         1:       return 18'd4095;
         2:       return 18'd4096;
         3:       return IW'($urandom_range(40, 60));
         default: return IW'($urandom_range(0, 18'h3FFFF));
      endcase
   endfunction

   logic [IW-1:0] sat_tab [16];

   initial begin
      repeat (3) @(posedge i_clk);
      do_reset();

      // Plain frame of constant magnitude, always ready
      for (int i = 0; i < W * H; i++) step(1'b1, 18'd100, 1'b1);
      drain();
      n_tests++;
      if (fd_seen != 1) begin
         n_fail++;
         $display("FAIL frame_done_count: got %0d expected 1", fd_seen);
      end

      // Saturation / threshold corners at non-border positions
      for (int i = 0; i < 16; i++) sat_tab[i] = 18'd77;
`ifdef CONV_SINK_THRESH_EN
      sat_tab[10] = 18'd49;
      sat_tab[11] = 18'd50;
      sat_tab[14] = 18'd51;
      sat_tab[15] = 18'h3FFFF;
`else
      sat_tab[10] = 18'h3FFFF;
      sat_tab[11] = 18'd4095;
      sat_tab[14] = 18'd4096;
      sat_tab[15] = 18'd4094;
`endif
      for (int i = 0; i < 16; i++) step(1'b1, sat_tab[i], 1'b1);
      drain();

      // Fill, then push and pop together while full: no drop
      for (int i = 0; i < D; i++) step(1'b1, rand_val(), 1'b0);
      step(1'b1, rand_val(), 1'b1);
      step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b0);
      chk("full_pushpop_no_ovf", 32'(o_overflow), 32'd0);
      drain();

      // Six samples into a stalled buffer: two dropped, overflow sticks
      for (int i = 0; i < 6; i++) step(1'b1, rand_val(), 1'b0);
      step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b0);
      chk("overflow_set", 32'(o_overflow), 32'd1);
      drain();
      for (int i = 0; i < 2 * W * H; i++) step(1'b1, rand_val(), 1'b1);
      drain();

      // Randomised traffic with backpressure
      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 9) < 7), rand_val(), ($urandom_range(0, 9) < 6));
      drain();

      // Reset mid-line 2 with a partly full buffer
      do_reset();
      for (int i = 0; i < 6; i++) step(1'b1, rand_val(), 1'b0);
      step(1'b0, '0, 1'b0);
      chk("busy_before_reset", 32'(o_busy), 32'd1);
      do_reset();
      step(1'b1, 18'd7, 1'b1);
      step(1'b0, '0, 1'b1);
      chk("busy_after_reset", 32'(o_busy), 32'd1);
      for (int i = 0; i < 3 * W * H; i++) step(1'b1, rand_val(), ($urandom_range(0, 3) != 0));
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
